// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake on both sides, status flags and an optional
// iterative shift-add multiplier (opcode 11).
module alu_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned MSB = WIDTH - 1;
  localparam logic [SHW-1:0] LAST_CNT = SHW'(WIDTH - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t           r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;
  logic             r_overflow;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;

  logic             w_out_free;
  logic             w_accept;
  logic             w_is_mul;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_def;
  logic [WIDTH-1:0] w_acc_step;

  assign w_out_free = !r_out_valid || out_ready;
  assign in_ready   = (r_state == IDLE) && w_out_free;
  assign w_accept   = in_valid && in_ready;
  assign w_is_mul   = MUL_EN && (alu_control == 4'd11);
  assign w_sum      = {1'b0, A} + {1'b0, B};
  assign w_diff     = {1'b0, A} - {1'b0, B};
  assign w_shamt    = B[SHW-1:0];
  assign w_acc_step = r_mplier[0] ? r_acc + r_mcand : r_acc;

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign overflow  = r_overflow;
  assign busy      = (r_state == MUL);

  // Single-cycle datapath; opcode 11 lands in default and is overridden by the FSM when enabled.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_def = 1'b1;
    case (alu_control)
      4'd0: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (A[MSB] == B[MSB]) && (w_sum[MSB] != A[MSB]);
      end
      4'd1: w_res = A & B;
      4'd2: w_res = B;
      4'd3: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (A[MSB] != B[MSB]) && (w_diff[MSB] != A[MSB]);
      end
      4'd4:  w_res = A | B;
      4'd5:  w_res = A ^ B;
      4'd6:  w_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      4'd7:  w_res = {{(WIDTH-1){1'b0}}, A < B};
      4'd8:  w_res = A << w_shamt;
      4'd9:  w_res = A >> w_shamt;
      4'd10: w_res = $signed(A) >>> w_shamt;
      default: w_def = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_state  <= MUL;
              r_mcand  <= A;
              r_mplier <= B;
              r_acc    <= '0;
              r_cnt    <= '0;
            end else begin
              r_result    <= w_res;
              r_zero      <= w_def && (w_res == '0);
              r_carry     <= w_c;
              r_overflow  <= w_v;
              r_out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          // The final iteration writes straight into the output register, so it waits
          // (frozen) until that register is free.
          if (r_cnt != LAST_CNT) begin
            r_acc    <= w_acc_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
          end else if (w_out_free) begin
            r_acc       <= w_acc_step;
            r_result    <= w_acc_step;
            r_zero      <= (w_acc_step == '0);
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus a randomized scoreboard run
// against an arithmetic reference model.
module tb_alu_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] A, B, result;
  logic [3:0]  alu_control;
  logic        zero, carry, overflow, busy;

  logic        nm_in_valid, nm_in_ready, nm_out_valid, nm_out_ready;
  logic [31:0] nm_A, nm_B, nm_result;
  logic [3:0]  nm_alu_control;
  logic        nm_zero, nm_carry, nm_overflow, nm_busy;

  int n_checks = 0;
  int n_pass   = 0;

  alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .alu_control(alu_control), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .carry(carry), .overflow(overflow), .busy(busy)
  );

  alu_pipe #(.WIDTH(32), .MUL_EN(1'b0)) dut_nm (
    .clk(clk), .reset(reset), .in_valid(nm_in_valid), .in_ready(nm_in_ready), .A(nm_A),
    .B(nm_B), .alu_control(nm_alu_control), .out_valid(nm_out_valid),
    .out_ready(nm_out_ready), .result(nm_result), .zero(nm_zero), .carry(nm_carry),
    .overflow(nm_overflow), .busy(nm_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // Reference: {result, zero, carry, overflow} from plain 64-bit arithmetic.
  function automatic logic [34:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input bit mul_en);
    longint unsigned ua, ub, full;
    longint          sa, sb, s;
    int              sh;
    logic [31:0]     r;
    logic            c, v, def;
    ua = a; ub = b;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(ub % 32);
    r = '0; c = 1'b0; v = 1'b0; def = 1'b1;
    case (op)
      4'd0: begin
        full = ua + ub; r = full[31:0]; c = full[32];
        s = sa + sb; v = (s != longint'($signed(s[31:0])));
      end
      4'd1: r = a & b;
      4'd2: r = b;
      4'd3: begin
        full = ua - ub; r = full[31:0]; c = (ua < ub);
        s = sa - sb; v = (s != longint'($signed(s[31:0])));
      end
      4'd4:  r = a | b;
      4'd5:  r = a ^ b;
      4'd6:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd7:  r = (ua < ub) ? 32'd1 : 32'd0;
      4'd8:  r = a << sh;
      4'd9:  r = a >> sh;
      4'd10: begin s = sa >>> sh; r = s[31:0]; end
      4'd11: if (mul_en) begin full = ua * ub; r = full[31:0]; end else def = 1'b0;
      default: def = 1'b0;
    endcase
    return {r, def && (r == 32'd0), c, v};
  endfunction

  // Drives one op from a negedge; returns at the negedge of the cycle after acceptance.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int k;
    in_valid = 1'b1; alu_control = op; A = a; B = b;
    #1;
    k = 0;
    while (!in_ready && k < 100) begin @(negedge clk); #1; k++; end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL do_op_accept op=%0d in_ready stuck at 0 after %0d cycles", op, k);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    got = {out_valid, zero, carry, overflow, busy, |result};
    n_checks++;
    if (got !== 6'b0) $display("FAIL reset_outputs got %b want 000000", got);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_arith();
    logic [35:0] got, exp;
    logic [3:0]  ops [5] = '{4'd0, 4'd3, 4'd3, 4'd10, 4'd6};
    logic [31:0] as  [5] = '{32'h7FFFFFFF, 32'd5, 32'd7, 32'h80000010, 32'hFFFFFFFF};
    logic [31:0] bs  [5] = '{32'd1, 32'd7, 32'd7, 32'h00000104, 32'd1};
    logic [31:0] rs  [5] = '{32'h80000000, 32'hFFFFFFFE, 32'd0, 32'hF8000001, 32'd1};
    logic [2:0]  fs  [5] = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_op(ops[i], as[i], bs[i]);
      got = {out_valid, result, zero, carry, overflow};
      exp = {1'b1, rs[i], fs[i]};
      n_checks++;
      if (got !== exp) $display("FAIL arith_%0d op=%0d got %h want %h", i, ops[i], got, exp);
      else n_pass++;
    end
    do_op(4'd7, 32'hFFFFFFFF, 32'd1);
    got = {out_valid, result, zero, carry, overflow};
    exp = {1'b1, 32'd0, 3'b100};
    n_checks++;
    if (got !== exp) $display("FAIL arith_sltu got %h want %h", got, exp);
    else n_pass++;
    do_op(4'd13, 32'd5, 32'd5);
    got = {out_valid, result, zero, carry, overflow};
    exp = {1'b1, 32'd0, 3'b000};
    n_checks++;
    if (got !== exp) $display("FAIL arith_undef13 got %h want %h", got, exp);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [2:0]  st;
    logic [33:0] got;
    out_ready = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) out_ready = 1'b0;
      in_valid = 1'b1; alu_control = 4'd11; A = 32'd7; B = 32'd6;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL mul%0d_accept in_ready got %b want 1", pass, in_ready);
      else n_pass++;
      @(negedge clk);
      in_valid = 1'b0; A = 32'hDEAD; B = 32'hBEEF;
      for (int i = 1; i <= 32; i++) begin
        st = {busy, in_ready, out_valid};
        n_checks++;
        if (st !== 3'b100) $display("FAIL mul%0d_busy cycle N+%0d got %b want 100", pass, i, st);
        else n_pass++;
        @(negedge clk);
      end
      got = {out_valid, busy, result};
      n_checks++;
      if (got !== {2'b10, 32'd42}) $display("FAIL mul%0d_done got %h want %h", pass, got,
                                            {2'b10, 32'd42});
      else n_pass++;
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      got = {out_valid, in_ready, result};
      n_checks++;
      if (got !== {2'b10, 32'd42}) $display("FAIL mul_hold_%0d got %h want %h", i, got,
                                            {2'b10, 32'd42});
      else n_pass++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL mul_release in_ready got %b want 1", in_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL mul_consumed out_valid got %b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [3] = '{4'd0, 4'd1, 4'd2};
    logic [31:0] as  [3] = '{32'd3, 32'hF0, 32'd5};
    logic [31:0] bs  [3] = '{32'd4, 32'h3C, 32'h99};
    logic [31:0] rs  [3] = '{32'd7, 32'h30, 32'h99};
    logic [32:0] got;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; alu_control = ops[i]; A = as[i]; B = bs[i];
      @(negedge clk);
      got = {out_valid, result};
      n_checks++;
      if (got !== {1'b1, rs[i]}) $display("FAIL b2b_%0d got %h want %h", i, got, {1'b1, rs[i]});
      else n_pass++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL b2b_drain out_valid got %b want 0", out_valid);
    else n_pass++;
    // Stall: the second op must wait, then appear exactly once.
    in_valid = 1'b1; alu_control = 4'd0; A = 32'd10; B = 32'd20;
    @(negedge clk);
    out_ready = 1'b0; alu_control = 4'd1; A = 32'hFF; B = 32'h0F;
    for (int i = 0; i < 3; i++) begin
      #1;
      got = {out_valid, result};
      n_checks++;
      if (got !== {1'b1, 32'd30} || in_ready !== 1'b0)
        $display("FAIL b2b_stall_%0d got %h rdy %b want %h rdy 0", i, got, in_ready,
                 {1'b1, 32'd30});
      else n_pass++;
      if (i < 2) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    got = {out_valid, result};
    n_checks++;
    if (got !== {1'b1, 32'h0F}) $display("FAIL b2b_after_stall got %h want %h", got,
                                         {1'b1, 32'h0F});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL b2b_no_dup out_valid got %b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [34:0] q[$];
    logic [34:0] e;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      alu_control = 4'($urandom_range(0, 15));
      B           = $urandom;
      A           = ($urandom_range(0, 7) == 0) ? B : $urandom;
      out_ready   = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) $display("FAIL rand_extra result %h with empty scoreboard", result);
        else begin
          e = q.pop_front();
          if ({result, zero, carry, overflow} !== e)
            $display("FAIL rand_cmp cycle %0d got %h want %h", cyc,
                     {result, zero, carry, overflow}, e);
          else n_pass++;
        end
      end
      if (in_valid && in_ready) q.push_back(model(alu_control, A, B, 1'b1));
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && q.size() != 0; k++) begin
      #1;
      if (out_valid) begin
        e = q.pop_front();
        n_checks++;
        if ({result, zero, carry, overflow} !== e)
          $display("FAIL rand_drain got %h want %h", {result, zero, carry, overflow}, e);
        else n_pass++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (q.size() != 0 || out_valid !== 1'b0)
      $display("FAIL rand_empty pending %0d out_valid %b want 0 and 0", q.size(), out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_mul();
    logic [37:0] got;
    int          seen;
    logic [35:0] r;
    out_ready = 1'b1;
    do_op(4'd0, 32'd5, 32'd5);
    @(negedge clk);
    in_valid = 1'b1; alu_control = 4'd11; A = 32'd7; B = 32'd6;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    got = {out_valid, result, zero, carry, overflow, busy, 1'b0};
    n_checks++;
    if (got !== 38'd0) $display("FAIL rst_mid_mul outputs got %h want 0", got);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL rst_release in_ready got %b want 1", in_ready);
    else n_pass++;
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid || busy) seen++; end
    n_checks++;
    if (seen != 0) $display("FAIL rst_no_result got %0d active cycles want 0", seen);
    else n_pass++;
    do_op(4'd0, 32'd1, 32'd1);
    r = {out_valid, result, zero, carry, overflow};
    n_checks++;
    if (r !== {1'b1, 32'd2, 3'b000}) $display("FAIL rst_add got %h want %h", r,
                                              {1'b1, 32'd2, 3'b000});
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_mul_disabled();
    logic [36:0] got;
    nm_out_ready = 1'b1;
    nm_in_valid = 1'b1; nm_alu_control = 4'd11; nm_A = 32'd7; nm_B = 32'd6;
    #1;
    n_checks++;
    if (nm_in_ready !== 1'b1) $display("FAIL nomul_accept got %b want 1", nm_in_ready);
    else n_pass++;
    @(negedge clk);
    nm_alu_control = 4'd0; nm_A = 32'd2; nm_B = 32'd3;
    got = {nm_out_valid, nm_result, nm_zero, nm_carry, nm_overflow, nm_busy};
    n_checks++;
    if (got !== {1'b1, 32'd0, 4'b0000}) $display("FAIL nomul_op11 got %h want %h", got,
                                                 {1'b1, 32'd0, 4'b0000});
    else n_pass++;
    @(negedge clk);
    nm_in_valid = 1'b0;
    got = {nm_out_valid, nm_result, nm_zero, nm_carry, nm_overflow, nm_busy};
    n_checks++;
    if (got !== {1'b1, 32'd5, 4'b0000}) $display("FAIL nomul_add got %h want %h", got,
                                                 {1'b1, 32'd5, 4'b0000});
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; alu_control = '0;
    nm_in_valid = 1'b0; nm_out_ready = 1'b1; nm_A = '0; nm_B = '0; nm_alu_control = '0;
    @(negedge clk);
    test_reset();
    test_arith();
    test_mul();
    test_back_to_back();
    test_random();
    test_reset_mid_mul();
    test_mul_disabled();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
